sram_burst_ctrl: RTL and testbench

Parametrised SRAM access sequencer for the AES datapath, generalising the fixed-length, fixed-width SRAM controllers. It takes a base address, a run-time burst length and a direction, then issues one SRAM read or write strobe per cycle, throttled by an upstream/downstream ready. It tracks read latency so the consumer gets a read-data-valid strobe, and reports completion or abort with a level-held done. It sits between the key/state scheduler and an SRAM macro.

---
 rtl/sram_ctrl_pkg.sv | 5 +
 rtl/sram_burst_ctrl_if.sv | 28 ++
 rtl/burst_addr_counter.sv | 33 +++
 rtl/sram_burst_ctrl.sv | 106 ++++++++++
 tb/tb_sram_burst_ctrl.sv | 132 +++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding and read-latency bound for the SRAM burst sequencer
package sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;
  localparam int RD_LAT_MAX = 4;
endpackage

// File: rtl/sram_burst_ctrl_if.sv
// sram_burst_ctrl_if: request, SRAM strobe and status bundle between scheduler and sequencer
interface sram_burst_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              data_ready;
  logic              abort;
  logic              sram_r_en;
  logic              sram_w_en;
  logic [ADDR_W-1:0] sram_addr;
  logic              rdata_valid;
  logic [LEN_W-1:0]  word_idx;
  logic              busy;
  logic              done;
  logic              aborted;
  modport master (
    output start, dir, base_addr, burst_len, data_ready, abort,
    input  sram_r_en, sram_w_en, sram_addr, rdata_valid, word_idx, busy, done, aborted
  );
  modport slave (
    input  start, dir, base_addr, burst_len, data_ready, abort,
    output sram_r_en, sram_w_en, sram_addr, rdata_valid, word_idx, busy, done, aborted
  );
endinterface

// File: rtl/burst_addr_counter.sv
// burst_addr_counter: holds burst base/length and walks the word index, flagging the final word
module burst_addr_counter #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  idx,
  output logic              last
);
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt;
  // load captures a new burst and clears the index; enable advances one word
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      base_r <= '0;
      len_r  <= '0;
      cnt    <= '0;
    end else if (load) begin
      base_r <= base;
      len_r  <= len;
      cnt    <= '0;
    end else if (enable) cnt <= cnt + LEN_W'(1);
  assign addr = base_r + ADDR_W'(cnt);
  assign idx  = cnt;
  assign last = cnt == len_r - LEN_W'(1);
endmodule

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: issues a throttled burst of SRAM read/write strobes and tracks read latency
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         n_rst,
  sram_burst_ctrl_if.slave bus
);
  localparam int LAT     = RD_LAT > RD_LAT_MAX ? RD_LAT_MAX : RD_LAT;
  localparam bit HAS_LAT = LAT > 0;
  state_t            state;
  logic              dir_r;
  logic              busy_r;
  logic              done_r;
  logic              aborted_r;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  idx;
  logic              last;
  logic              load;
  logic              fire;
  logic              rd_fire;
  logic              pend;
  logic              drain;
  assign load    = state == IDLE && bus.start && bus.burst_len != '0;
  assign fire    = state == ACCESS && bus.data_ready && !bus.abort;
  assign rd_fire = fire && dir_r;
  assign drain   = dir_r && HAS_LAT;
  burst_addr_counter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_cnt (
    .clk(clk), .n_rst(n_rst), .load(load), .enable(fire),
    .base(bus.base_addr), .len(bus.burst_len), .addr(addr), .idx(idx), .last(last)
  );
  generate
    if (LAT == 0) begin : g_nolat
      assign bus.rdata_valid = rd_fire;
      assign pend = 1'b0;
    end else begin : g_lat
      logic [LAT-1:0] sr;
      // read-valid delay line; keeps shifting after abort so in-flight reads retire
      always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) sr <= '0;
        else begin
          sr[0] <= rd_fire;
          for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
      // reads still in flight after this cycle's valid; DRAIN exits once none remain
      always_comb begin
        pend = 1'b0;
        for (int i = 0; i < LAT - 1; i++) pend = pend | sr[i];
      end
      assign bus.rdata_valid = sr[LAT-1];
    end
  endgenerate
  // burst sequencer with registered status flags
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state     <= IDLE;
      dir_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.start) begin
            dir_r  <= bus.dir;
            state  <= load ? ACCESS : DONE;
            busy_r <= load;
            done_r <= !load;
          end
        ACCESS:
          if (bus.abort) begin
            state     <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= 1'b1;
          end else if (bus.data_ready && last) begin
            state  <= drain ? DRAIN : DONE;
            busy_r <= drain;
            done_r <= !drain;
          end
        DRAIN:
          if (bus.abort || !pend) begin
            state     <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= bus.abort;
          end
        default:
          if (!bus.start) begin
            state     <= IDLE;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
          end
      endcase
  assign bus.sram_r_en = rd_fire;
  assign bus.sram_w_en = fire && !dir_r;
  assign bus.sram_addr = state == ACCESS ? addr : '0;
  assign bus.word_idx  = state == ACCESS ? idx : '0;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.aborted   = aborted_r;
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb_sram_burst_ctrl: directed checks of write, read, throttle/wrap, abort, zero-length and reset
module tb_sram_burst_ctrl;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  sram_burst_ctrl_if #(.ADDR_W(8), .LEN_W(8)) bus();
  sram_burst_ctrl #(.ADDR_W(8), .LEN_W(8), .RD_LAT(2)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic go();
    @(posedge clk);
    #2;
  endtask
  task automatic write_burst(input string tag);
    go();
    bus.start = 1'b1; bus.dir = 1'b0; bus.base_addr = 8'h10; bus.burst_len = 8'd4;
    bus.data_ready = 1'b1; bus.abort = 1'b0;
    #2;
    check({tag, "_idle_busy"}, bus.busy, 0);
    for (int i = 0; i < 4; i++) begin
      go(); #2;
      check({tag, "_w_en"}, bus.sram_w_en, 1);
      check({tag, "_r_en"}, bus.sram_r_en, 0);
      check({tag, "_addr"}, bus.sram_addr, 32'h10 + i);
      check({tag, "_idx"}, bus.word_idx, i);
      check({tag, "_busy"}, bus.busy, 1);
    end
    go(); bus.start = 1'b0; #2;
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_aborted"}, bus.aborted, 0);
    check({tag, "_busy_end"}, bus.busy, 0);
    check({tag, "_w_en_end"}, bus.sram_w_en, 0);
    go(); #2;
    check({tag, "_done_clr"}, bus.done, 0);
  endtask
  initial begin
    logic [5:0] er, ev, eb, ed;
    bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = '0; bus.burst_len = '0;
    bus.data_ready = 1'b0; bus.abort = 1'b0;
    #12;
    check("rst_r_en", bus.sram_r_en, 0);
    check("rst_w_en", bus.sram_w_en, 0);
    check("rst_addr", bus.sram_addr, 0);
    check("rst_valid", bus.rdata_valid, 0);
    check("rst_idx", bus.word_idx, 0);
    check("rst_status", {bus.busy, bus.done, bus.aborted}, 0);
    go(); n_rst = 1'b1;
    write_burst("wr");
    go();
    bus.start = 1'b1; bus.dir = 1'b1; bus.base_addr = 8'h20; bus.burst_len = 8'd3;
    er = 6'b000111; ev = 6'b011100; eb = 6'b011111; ed = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      go(); #2;
      check("rd_r_en", bus.sram_r_en, er[i]);
      check("rd_w_en", bus.sram_w_en, 0);
      check("rd_valid", bus.rdata_valid, ev[i]);
      check("rd_busy", bus.busy, eb[i]);
      check("rd_done", bus.done, ed[i]);
      if (i < 3) check("rd_addr", bus.sram_addr, 32'h20 + i);
    end
    check("rd_aborted", bus.aborted, 0);
    go(); bus.start = 1'b0; #2;
    check("rd_done_hold", bus.done, 1);
    go(); #2;
    check("rd_done_clr", bus.done, 0);
    go();
    bus.start = 1'b1; bus.dir = 1'b0; bus.base_addr = 8'hFE; bus.burst_len = 8'd4; bus.data_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      go();
      bus.data_ready = (i % 2 == 0);
      #2;
      check("wrap_w_en", bus.sram_w_en, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) begin
        check("wrap_addr", bus.sram_addr, (32'hFE + i / 2) & 32'hFF);
        check("wrap_idx", bus.word_idx, i / 2);
      end
    end
    go(); bus.start = 1'b0; bus.data_ready = 1'b1; #2;
    check("wrap_done", bus.done, 1);
    check("wrap_aborted", bus.aborted, 0);
    go();
    bus.start = 1'b1; bus.dir = 1'b0; bus.base_addr = 8'h40; bus.burst_len = 8'd8;
    go(); #2;
    check("ab_w_en1", bus.sram_w_en, 1);
    check("ab_addr1", bus.sram_addr, 32'h40);
    go(); bus.abort = 1'b1; #2;
    check("ab_w_en2", bus.sram_w_en, 0);
    go(); bus.abort = 1'b0; #2;
    check("ab_done", bus.done, 1);
    check("ab_aborted", bus.aborted, 1);
    check("ab_busy", bus.busy, 0);
    bus.start = 1'b0;
    go(); #2;
    check("ab_clr", {bus.done, bus.aborted}, 0);
    go(); bus.abort = 1'b1; #2;
    go(); bus.abort = 1'b0; #2;
    check("idle_abort", {bus.busy, bus.done, bus.aborted}, 0);
    go(); bus.start = 1'b1; bus.burst_len = 8'd0;
    go(); #2;
    check("zl_done", bus.done, 1);
    check("zl_aborted", bus.aborted, 0);
    check("zl_strobes", {bus.sram_r_en, bus.sram_w_en}, 0);
    check("zl_busy", bus.busy, 0);
    bus.start = 1'b0;
    go(); #2;
    check("zl_clr", bus.done, 0);
    go();
    bus.start = 1'b1; bus.dir = 1'b1; bus.base_addr = 8'h30; bus.burst_len = 8'd5;
    go(); go(); go(); #2;
    check("mr_r_en", bus.sram_r_en, 1);
    check("mr_valid", bus.rdata_valid, 1);
    check("mr_addr", bus.sram_addr, 32'h32);
    n_rst = 1'b0; bus.start = 1'b0;
    #1;
    check("mr_rst_r_en", bus.sram_r_en, 0);
    check("mr_rst_valid", bus.rdata_valid, 0);
    check("mr_rst_addr", bus.sram_addr, 0);
    check("mr_rst_idx", bus.word_idx, 0);
    check("mr_rst_status", {bus.busy, bus.done, bus.aborted}, 0);
    go(); n_rst = 1'b1;
    write_burst("wr2");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
